interrupt_request_priority: RTL

INTERRUPT_REQUEST_PRIORITY -- requirements
Module: interrupt_request_priority

---
 rtl/interrupt_request_priority_if.sv | 49 ++++
 rtl/interrupt_request_priority.sv | 101 ++++++++++
 2 files changed

// File: rtl/interrupt_request_priority_if.sv
// Signal bundle between the interrupt control logic and the request/priority block.
// The slave side is the priority block; the master side drives requests and control.
interface interrupt_request_priority_if;
  logic [7:0] interrupt_request_pin;
  logic       level_or_edge_toriggered_config;
  logic       special_fully_nest_config;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] interrupt_mask;
  logic       latch_in_service;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] interrupt;
  logic [7:0] highest_level_in_service;
  logic [7:0] interrupt_request_register;
  logic [7:0] in_service_register;

  modport slave (
    input  interrupt_request_pin,
    input  level_or_edge_toriggered_config,
    input  special_fully_nest_config,
    input  freeze,
    input  clear_interrupt_request,
    input  interrupt_mask,
    input  latch_in_service,
    input  end_of_interrupt,
    input  priority_rotate,
    output interrupt,
    output highest_level_in_service,
    output interrupt_request_register,
    output in_service_register
  );

  modport master (
    output interrupt_request_pin,
    output level_or_edge_toriggered_config,
    output special_fully_nest_config,
    output freeze,
    output clear_interrupt_request,
    output interrupt_mask,
    output latch_in_service,
    output end_of_interrupt,
    output priority_rotate,
    input  interrupt,
    input  highest_level_in_service,
    input  interrupt_request_register,
    input  in_service_register
  );
endinterface

// File: rtl/interrupt_request_priority.sv
// 8-level interrupt request latch, rotating-priority resolver and in-service tracking.
// Priority is resolved in a rotated frame where bit 0 is always the highest level.
module interrupt_request_priority (
  input  logic                          clock,
  input  logic                          reset_n,
  interrupt_request_priority_if.slave   bus
);

  logic [7:0] pin_d;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] interrupt_q;

  logic [7:0] irr_next;
  logic [7:0] isr_next;
  logic [7:0] interrupt_next;
  logic [2:0] top_level;
  logic [7:0] candidate;
  logic [7:0] cand_rank;
  logic [7:0] win_rank;
  logic [7:0] isr_rank;
  logic [7:0] hlis_rank;
  logic [7:0] winner;
  logic [7:0] hlis;
  logic       win_valid;

  function automatic logic [7:0] rot_right(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction

  function automatic logic [7:0] rot_left(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] lowest_one(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  // Edge mode: set on a rising edge, hold while the pin stays high, drop when it falls.
  always_comb begin
    irr_next = '0;
    if (bus.level_or_edge_toriggered_config)
      irr_next = bus.interrupt_request_pin;
    else
      irr_next = (bus.interrupt_request_pin & ~pin_d) | (irr & bus.interrupt_request_pin);
    irr_next = irr_next & ~bus.clear_interrupt_request;
  end

  // After rotating by top_level, a lower bit index means a higher priority, so
  // one-hot ranks compare directly as unsigned numbers.
  always_comb begin
    top_level = bus.priority_rotate + 3'd1;
    candidate = irr & ~bus.interrupt_mask;
    cand_rank = rot_right(candidate, top_level);
    win_rank  = lowest_one(cand_rank);
    isr_rank  = rot_right(isr, top_level);
    hlis_rank = lowest_one(isr_rank);
    winner    = rot_left(win_rank, top_level);
    hlis      = rot_left(hlis_rank, top_level);
    win_valid = 1'b0;
    if (win_rank != 8'd0) begin
      if (isr == 8'd0)
        win_valid = 1'b1;
      else if (bus.special_fully_nest_config)
        win_valid = (win_rank <= hlis_rank);
      else
        win_valid = (win_rank < hlis_rank);
    end
  end

  always_comb begin
    interrupt_next = interrupt_q;
    if (!bus.freeze)
      interrupt_next = win_valid ? winner : 8'd0;
    isr_next = (isr & ~bus.end_of_interrupt) | (bus.latch_in_service ? interrupt_q : 8'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pin_d       <= '0;
      irr         <= '0;
      isr         <= '0;
      interrupt_q <= '0;
    end else begin
      pin_d       <= bus.interrupt_request_pin;
      irr         <= irr_next;
      isr         <= isr_next;
      interrupt_q <= interrupt_next;
    end
  end

  assign bus.interrupt                  = interrupt_q;
  assign bus.highest_level_in_service   = hlis;
  assign bus.interrupt_request_register = irr;
  assign bus.in_service_register        = isr;

endmodule
